// File: rtl/uart_pkg.sv
// Shared types and defaults for the UART transmit scheduler.
package uart_pkg;

  localparam int UART_TX_DEPTH = 8;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_BUSY = 2'd1,
    WAIT_TC   = 2'd2
  } tx_state_t;

endpackage

// File: rtl/uart_fifo.sv
// Synchronous byte FIFO with push/pop/flush; caller guarantees no pop when empty
// and no push when full unless a pop happens in the same cycle.
module uart_fifo #(
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  logic [7:0]    wr_data,
  output logic [7:0]    rd_data,
  output logic [AW:0]   count,
  output logic          full,
  output logic          empty
);

  localparam logic [AW:0] DEPTH_CNT = (AW+1)'(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset; only entries written since the last flush are ever read.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  assign rd_data = mem[rd_ptr];
  assign full    = (count == DEPTH_CNT);
  assign empty   = (count == '0);

endmodule

// File: rtl/uart_tx_sched.sv
// Queues bus-written bytes and feeds them one at a time to the UART transmitter
// through its start/busy/tc handshake.
//   state     | meaning
//   IDLE      | no frame in flight; start next byte when enabled and queue non-empty
//   WAIT_BUSY | start issued, waiting for transmitter to raise busy
//   WAIT_TC   | frame in flight, waiting for terminal-count pulse
module uart_tx_sched
  import uart_pkg::*;
#(
  parameter int DEPTH = UART_TX_DEPTH,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          wr_en_i,
  input  logic [7:0]    wr_data_i,
  input  logic          flush_i,
  input  logic          tx_en_i,
  input  logic          ovf_clr_i,
  output logic          full_o,
  output logic          empty_o,
  output logic [AW:0]   count_o,
  output logic          ovf_o,
  output logic          done_o,
  output logic          tx_start_o,
  output logic [7:0]    tx_data_o,
  input  logic          tx_busy_i,
  input  logic          tx_tc_i
);

  tx_state_t  state, state_nxt;
  logic       pop;
  logic       push;
  logic       wr_ok;
  logic       ovf_hit;
  logic       start_nxt;
  logic [7:0] data_nxt;
  logic       done_nxt;
  logic [7:0] head;

  uart_fifo #(.DEPTH(DEPTH), .AW(AW)) u_fifo (
    .clk     (clk_i),
    .rst     (rst_i),
    .push    (push),
    .pop     (pop),
    .flush   (flush_i),
    .wr_data (wr_data_i),
    .rd_data (head),
    .count   (count_o),
    .full    (full_o),
    .empty   (empty_o)
  );

  // A pop in the same cycle frees a slot, so a write into a full queue still lands.
  assign wr_ok   = wr_en_i && !flush_i;
  assign push    = wr_ok && (!full_o || pop);
  assign ovf_hit = wr_ok && full_o && !pop;

  assign done_nxt = (state == WAIT_TC) && tx_tc_i && empty_o && !push;

  always_comb begin
    state_nxt = state;
    start_nxt = 1'b0;
    data_nxt  = tx_data_o;
    pop       = 1'b0;
    case (state)
      IDLE: begin
        if (tx_en_i && !empty_o && !tx_busy_i && !flush_i) begin
          pop       = 1'b1;
          start_nxt = 1'b1;
          data_nxt  = head;
          state_nxt = WAIT_BUSY;
        end
      end
      WAIT_BUSY: begin
        if (tx_busy_i) state_nxt = WAIT_TC;
      end
      WAIT_TC: begin
        if (tx_tc_i) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= IDLE;
      tx_start_o <= 1'b0;
      tx_data_o  <= 8'h00;
      done_o     <= 1'b0;
    end else begin
      state      <= state_nxt;
      tx_start_o <= start_nxt;
      tx_data_o  <= data_nxt;
      done_o     <= done_nxt;
    end
  end

  // New overflow beats a simultaneous clear.
  always_ff @(posedge clk_i) begin
    if (rst_i)          ovf_o <= 1'b0;
    else if (ovf_hit)   ovf_o <= 1'b1;
    else if (ovf_clr_i) ovf_o <= 1'b0;
  end

endmodule
